// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, operand widths and output-enable constant for the sequential divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DVD_W = 8;
    localparam int DVR_W = 4;
    localparam logic [7:0] UIO_OE = 8'b1100_0000;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step over a 5-bit partial remainder.
module div_step
    import div_pkg::*;
(
    input  logic [DVR_W:0]   rem,
    input  logic [DVR_W-1:0] divisor,
    input  logic             din,
    output logic [DVR_W:0]   next_rem,
    output logic             q
);
    logic [DVR_W:0] sh;
    logic unused;
    // The incoming remainder is always below the divisor, so its top bit is never set.
    assign unused   = rem[DVR_W];
    assign sh       = {rem[DVR_W-1:0], din};
    assign q        = sh >= {1'b0, divisor};
    assign next_rem = q ? sh - {1'b0, divisor} : sh;
endmodule

// File: rtl/seq_array_divider.sv
// seq_array_divider: 8-by-4 unsigned restoring divider, one quotient bit per cycle, start on rising edge.
// Optional DIV_FAST_ZERO_EN: divide-by-zero completes in a single cycle instead of running all steps.
module seq_array_divider
    import div_pkg::*;
#(
    parameter int ITER = DVD_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = $clog2(ITER);

    state_t           state;
    logic [CW-1:0]    cnt, idx;
    logic [DVD_W-1:0] dvd, quo, q_res, r_res, quo_nx;
    logic [DVR_W-1:0] dvr;
    logic [DVR_W:0]   rem, nrem;
    logic             qb, start_q, armed, go, unused;

    assign unused = &{1'b0, uio_in[7:6]};
    // armed blocks a start level that was already high when reset released
    assign go     = uio_in[4] & ~start_q & armed;
    assign idx    = CW'(ITER - 1) - cnt;
    assign quo_nx = {quo[DVD_W-2:0], qb};

    div_step u_step (
        .rem      (rem),
        .divisor  (dvr),
        .din      (dvd[idx]),
        .next_rem (nrem),
        .q        (qb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            dvd     <= '0;
            dvr     <= '0;
            rem     <= '0;
            quo     <= '0;
            q_res   <= '0;
            r_res   <= '0;
            start_q <= 1'b0;
            armed   <= 1'b0;
        end else if (ena) begin
            start_q <= uio_in[4];
            if (!uio_in[4]) armed <= 1'b1;
            case (state)
                IDLE, DONE: if (go) begin
                    dvd   <= ui_in;
                    dvr   <= uio_in[DVR_W-1:0];
                    rem   <= '0;
                    quo   <= '0;
                    cnt   <= '0;
                    state <= RUN;
`ifdef DIV_FAST_ZERO_EN
                    if (uio_in[DVR_W-1:0] == '0) begin
                        q_res <= '1;
                        r_res <= ui_in;
                        state <= DONE;
                    end
`endif
                end
                RUN: begin
                    rem <= nrem;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        state <= DONE;
                        q_res <= quo_nx;
                        // divide-by-zero leaves the truncated shift register in rem, so report the dividend
                        r_res <= (dvr == '0) ? dvd : {{(DVD_W-DVR_W-1){1'b0}}, nrem};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uo_out  = uio_in[5] ? r_res : q_res;
    assign uio_out = {state == DONE, state == RUN, 6'b0};
    assign uio_oe  = UIO_OE;
endmodule

// File: tb/tb_seq_array_divider.sv
// tb_seq_array_divider: table-driven, random and corner-sequence checks of seq_array_divider against an arithmetic model.
module tb_seq_array_divider;
    logic       clk = 1'b0, rst = 1'b1, ena = 1'b1;
    logic [7:0] ui_in = 8'h00, uio_in = 8'h10;
    logic [7:0] uo_out, uio_out, uio_oe;
    int         checks = 0, errors = 0, cyc = 0, c0;
    logic [7:0] prev_q = 8'h00, prev_r = 8'h00;

`ifdef DIV_FAST_ZERO_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [7:0] r;
    } vec_t;
    vec_t tbl[8];

    seq_array_divider dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] mq(input logic [7:0] a, input logic [3:0] b);
        return (b == 0) ? 8'hFF : a / {4'b0, b};
    endfunction

    function automatic logic [7:0] mr(input logic [7:0] a, input logic [3:0] b);
        return (b == 0) ? a : a % {4'b0, b};
    endfunction

    task automatic wait_done(input int from, input int lat, input string tag);
        do begin
            @(posedge clk);
            #1;
        end while (!uio_out[7] && cyc - from < 30);
        chk({tag, "_latency"}, cyc - from, lat);
    endtask

    task automatic check_res(input logic [7:0] q, input logic [7:0] r, input string tag);
        uio_in[5] = 1'b0;
        #1 chk({tag, "_quot"}, uo_out, q);
        uio_in[5] = 1'b1;
        #1 chk({tag, "_rem"}, uo_out, r);
        uio_in[5] = 1'b0;
        prev_q = q;
        prev_r = r;
    endtask

    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk) uio_in[4] = 1'b0;
        @(negedge clk);
        ui_in       = a;
        uio_in[3:0] = b;
        uio_in[4]   = 1'b1;
        c0          = cyc;
    endtask

    task automatic op(input logic [7:0] a, input logic [3:0] b, input logic [7:0] q, input logic [7:0] r, input string tag);
        int lat;
        lat = (FAST && b == 0) ? 1 : 9;
        launch(a, b);
        if (lat == 9) begin
            @(posedge clk);
            #1 chk({tag, "_busy"}, uio_out, 8'h40);
            repeat (3) @(posedge clk);
            #1 chk({tag, "_hold_prev"}, uo_out, prev_q);
        end
        wait_done(c0, lat, tag);
        check_res(q, r, tag);
    endtask

    initial begin
        tbl[0] = '{8'd200, 4'd7,  8'h1C, 8'h04};
        tbl[1] = '{8'd255, 4'd15, 8'h11, 8'h00};
        tbl[2] = '{8'd0,   4'd5,  8'h00, 8'h00};
        tbl[3] = '{8'h0F,  4'd0,  8'hFF, 8'h0F};
        tbl[4] = '{8'd100, 4'd3,  8'd33, 8'd1};
        tbl[5] = '{8'd255, 4'd1,  8'hFF, 8'h00};
        tbl[6] = '{8'd14,  4'd15, 8'h00, 8'h0E};
        tbl[7] = '{8'd128, 4'd13, 8'd9,  8'd11};

        #2;
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_uo_out", uo_out, 8'h00);
        chk("uio_oe", uio_oe, 8'hC0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_start_after_reset", uio_out, 8'h00);

        foreach (tbl[i]) op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, $sformatf("tbl%0d", i));

        for (int i = 0; i < 20; i++) begin
            logic [7:0] a;
            logic [3:0] b;
            a = 8'($urandom_range(0, 255));
            b = 4'($urandom_range(0, 15));
            op(a, b, mq(a, b), mr(a, b), $sformatf("rnd%0d", i));
        end

        launch(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        uio_in[4]   = 1'b0;
        ui_in       = 8'd5;
        uio_in[3:0] = 4'd1;
        @(negedge clk) uio_in[4] = 1'b1;
        wait_done(c0, 9, "run_ignore");
        check_res(8'h1C, 8'h04, "run_ignore");

        repeat (3) @(negedge clk);
        chk("held_no_retrigger", uio_out, 8'h80);
        @(negedge clk) uio_in[4] = 1'b0;
        @(negedge clk);
        ui_in       = 8'd60;
        uio_in[3:0] = 4'd4;
        uio_in[4]   = 1'b1;
        c0          = cyc;
        @(posedge clk);
        #1 chk("retrigger_busy", uio_out, 8'h40);
        wait_done(c0, 9, "retrigger");
        check_res(8'd15, 8'd0, "retrigger");

        launch(8'd150, 4'd11);
        repeat (3) @(posedge clk);
        @(negedge clk) ena = 1'b0;
        repeat (4) @(negedge clk);
        ena = 1'b1;
        wait_done(c0, 13, "ena_stall");
        check_res(8'd13, 8'd7, "ena_stall");

        launch(8'd100, 4'd9);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_run_flags", uio_out, 8'h00);
        chk("rst_run_quot", uo_out, 8'h00);
        uio_in[5] = 1'b1;
        #1 chk("rst_run_rem", uo_out, 8'h00);
        uio_in[5] = 1'b0;
        @(negedge clk) rst = 1'b0;
        prev_q = 8'h00;
        prev_r = 8'h00;
        op(8'd77, 4'd5, 8'd15, 8'd2, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
